// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds or subtracts two WIDTH-bit operands CHUNK bits per
// clock cycle, LSB chunk first, through a small IDLE/BUSY/DONE FSM.
// WIDTH must be an integer multiple of CHUNK. CHUNK == WIDTH is legal and
// gives a single busy cycle.
// Optional feature: define SERIAL_CHUNK_ADDER_OVF_EN to add the registered
// signed-overflow output 'ovf'.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;        // latched operand A
  logic [WIDTH-1:0] b_q;        // latched operand B, already inverted for subtract
  logic [WIDTH-1:0] acc_q;      // chunk results collected so far
  logic             carry_q;    // carry into the chunk being added
  logic [CNT_W-1:0] cnt_q;      // index of the chunk being added

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  logic             msb_carry_in;
`endif

  // Add the current chunk and merge it into the partial result.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned and no latch is inferred.
    base       = int'(cnt_q) * CHUNK;
    a_chunk    = a_q[base +: CHUNK];
    b_chunk    = b_q[base +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_next   = acc_q;
    acc_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_chunk = (cnt_q == CNT_W'(N - 1));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    // The carry into the MSB is recovered from the MSB's own sum bit:
    // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
`endif
  end

  // FSM, operand/carry registers and registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so that every register
    // samples the pre-edge values, regardless of statement order.
    if (rst) begin
      // NOTE: the operand and carry registers are cleared along with the
      // control state so that an aborted operation leaves no trace.
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= BUSY;
          end else begin
            state <= IDLE;
          end
        end

        BUSY: begin
          acc_q   <= acc_next;
          carry_q <= chunk_sum[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            // The final chunk is folded straight into the output registers.
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= chunk_sum[CHUNK];
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            ovf   <= msb_carry_in ^ chunk_sum[CHUNK];
`endif
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
